// File: rtl/mem_arb_pkg.sv
// Shared FSM state type and default bus widths for the memory request arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 512;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping to the lowest.
// Zero latency; no backpressure of its own, the caller decides when a grant is taken.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [PTR_W-1:0]  gnt_idx_o,
    output logic              gnt_vld_o
);

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        // Upper segment [ptr, NUM_CH) has priority; a second pass covers the wrapped part.
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_vld_o && req_i[i] && (PTR_W'(i) >= ptr_i)) begin
                gnt_vld_o = 1'b1;
                gnt_o[i]  = 1'b1;
                gnt_idx_o = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_vld_o && req_i[i]) begin
                gnt_vld_o = 1'b1;
                gnt_o[i]  = 1'b1;
                gnt_idx_o = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter of NUM_CH line read/evict requesters onto one memory-controller port.
// One transaction in flight; accept in IDLE (reqReady combinational), issue next cycle, registered response.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH-1:0]        reqValid_i,
    input  logic [NUM_CH-1:0]        reqWrite_i,
    input  logic [NUM_CH*ADDR_W-1:0] reqAddr_i,
    input  logic [NUM_CH*LINE_W-1:0] reqData_i,
    output logic [NUM_CH-1:0]        reqReady_o,
    output logic [NUM_CH-1:0]        respValid_o,
    output logic                     respErr_o,
    output logic [LINE_W-1:0]        respData_o,
    output logic                     mcReqValid_o,
    output logic                     mcReqWrite_o,
    output logic [ADDR_W-1:0]        mcReqAddr_o,
    output logic [LINE_W-1:0]        mcReqData_o,
    input  logic                     mcReqReady_i,
    input  logic                     mcRespValid_i,
    input  logic [LINE_W-1:0]        mcRespData_i,
    input  logic                     mcWrDone_i,
    output logic                     timeoutEx_o,
    output logic                     busy_o
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NUM_CH-1:0] owner_q, owner_d;
    logic              mc_write_q, mc_write_d;
    logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
    logic [LINE_W-1:0] mc_data_q, mc_data_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [NUM_CH-1:0] resp_vld_q, resp_vld_d;
    logic              resp_err_q, resp_err_d;
    logic [LINE_W-1:0] resp_data_q, resp_data_d;
    logic              timeout_q, timeout_d;

    logic [NUM_CH-1:0] gnt;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_vld;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [LINE_W-1:0] sel_data;
    logic [TMR_W-1:0]  timer_inc;
    logic              done;
    logic              expire;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_rr (
        .req_i     (reqValid_i),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_write = reqWrite_i[i];
                sel_addr  = reqAddr_i[i*ADDR_W +: ADDR_W];
                sel_data  = reqData_i[i*LINE_W +: LINE_W];
            end
        end
    end

    // Saturating count of WAIT cycles including the current one.
    assign timer_inc = (&timer_q) ? timer_q : timer_q + TMR_W'(1);
    assign expire    = (TIMEOUT != 0) && (timer_inc == TMR_W'(TIMEOUT));
    assign done      = mc_write_q ? mcWrDone_i : mcRespValid_i;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        mc_write_d  = mc_write_q;
        mc_addr_d   = mc_addr_q;
        mc_data_d   = mc_data_q;
        timer_d     = timer_q;
        resp_vld_d  = '0;
        resp_err_d  = 1'b0;
        resp_data_d = resp_data_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    owner_d    = gnt;
                    mc_write_d = sel_write;
                    mc_addr_d  = sel_addr;
                    mc_data_d  = sel_data;
                    ptr_d      = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (mcReqReady_i) begin
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_inc;
                // A completion landing on the expiry cycle still counts as a success.
                if (done) begin
                    resp_vld_d = owner_q;
                    if (!mc_write_q) begin
                        resp_data_d = mcRespData_i;
                    end
                    state_d = IDLE;
                end else if (expire) begin
                    resp_vld_d = owner_q;
                    resp_err_d = 1'b1;
                    timeout_d  = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            mc_write_q  <= 1'b0;
            mc_addr_q   <= '0;
            mc_data_q   <= '0;
            timer_q     <= '0;
            resp_vld_q  <= '0;
            resp_err_q  <= 1'b0;
            resp_data_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            mc_write_q  <= mc_write_d;
            mc_addr_q   <= mc_addr_d;
            mc_data_q   <= mc_data_d;
            timer_q     <= timer_d;
            resp_vld_q  <= resp_vld_d;
            resp_err_q  <= resp_err_d;
            resp_data_q <= resp_data_d;
            timeout_q   <= timeout_d;
        end
    end

    assign reqReady_o   = (state_q == IDLE) ? gnt : '0;
    assign respValid_o  = resp_vld_q;
    assign respErr_o    = resp_err_q;
    assign respData_o   = resp_data_q;
    assign mcReqValid_o = (state_q == ISSUE);
    assign mcReqWrite_o = mc_write_q;
    assign mcReqAddr_o  = mc_addr_q;
    assign mcReqData_o  = mc_data_q;
    assign timeoutEx_o  = timeout_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter: a queue-based reference model predicts grants,
// issued requests and responses; independent monitors pop and compare at the negedge.
module tb_mem_req_arbiter;

    localparam int NUM_CH  = 2;
    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 512;
    localparam int TIMEOUT = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        reqValid;
    logic [NUM_CH-1:0]        reqWrite;
    logic [NUM_CH*ADDR_W-1:0] reqAddr;
    logic [NUM_CH*LINE_W-1:0] reqData;
    logic [NUM_CH-1:0]        reqReady;
    logic [NUM_CH-1:0]        respValid;
    logic                     respErr;
    logic [LINE_W-1:0]        respData;
    logic                     mcReqValid;
    logic                     mcReqWrite;
    logic [ADDR_W-1:0]        mcReqAddr;
    logic [LINE_W-1:0]        mcReqData;
    logic                     mcReqReady;
    logic                     mcRespValid;
    logic [LINE_W-1:0]        mcRespData;
    logic                     mcWrDone;
    logic                     timeoutEx;
    logic                     busy;

    mem_req_arbiter #(
        .NUM_CH  (NUM_CH),
        .ADDR_W  (ADDR_W),
        .LINE_W  (LINE_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .reqValid_i    (reqValid),
        .reqWrite_i    (reqWrite),
        .reqAddr_i     (reqAddr),
        .reqData_i     (reqData),
        .reqReady_o    (reqReady),
        .respValid_o   (respValid),
        .respErr_o     (respErr),
        .respData_o    (respData),
        .mcReqValid_o  (mcReqValid),
        .mcReqWrite_o  (mcReqWrite),
        .mcReqAddr_o   (mcReqAddr),
        .mcReqData_o   (mcReqData),
        .mcReqReady_i  (mcReqReady),
        .mcRespValid_i (mcRespValid),
        .mcRespData_i  (mcRespData),
        .mcWrDone_i    (mcWrDone),
        .timeoutEx_o   (timeoutEx),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } issue_t;

    typedef struct {
        int                ch;
        logic              err;
        logic [LINE_W-1:0] data;
        int                cyc;
    } resp_t;

    int     exp_grant_q[$];
    issue_t exp_issue_q[$];
    resp_t  exp_resp_q[$];

    // Reference model state: pending requests per channel, rotation pointer, last read line.
    bit                pend[NUM_CH];
    logic              p_wr[NUM_CH];
    logic [ADDR_W-1:0] p_addr[NUM_CH];
    logic [LINE_W-1:0] p_data[NUM_CH];
    int                ref_ptr   = 0;
    logic [LINE_W-1:0] last_data = '0;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic finish_tb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        v = '0;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int pick();
        for (int i = 0; i < NUM_CH; i++) begin
            if (pend[(ref_ptr + i) % NUM_CH]) return (ref_ptr + i) % NUM_CH;
        end
        return -1;
    endfunction

    function automatic int num_pend();
        int n = 0;
        for (int i = 0; i < NUM_CH; i++) n += int'(pend[i]);
        return n;
    endfunction

    task automatic add_req(input int ch, input logic wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        pend[ch]   = 1'b1;
        p_wr[ch]   = wr;
        p_addr[ch] = a;
        p_data[ch] = d;
        reqValid[ch] = 1'b1;
        reqWrite[ch] = wr;
        reqAddr[ch*ADDR_W +: ADDR_W] = a;
        reqData[ch*LINE_W +: LINE_W] = d;
    endtask

    task automatic add_random(input int ch);
        add_req(ch, 1'($urandom_range(0, 1)), $urandom, rand_line());
    endtask

    // Accept the model's predicted request and hand it to the controller after r stall cycles.
    // Returns with c_h = cycle number of the first WAIT cycle (called at its posedge + 1).
    task automatic issue_phase(input int r, output int g, output logic wr, output int c_h);
        issue_t            is;
        logic [NUM_CH-1:0] got;
        bit                seen;
        g = pick();
        exp_grant_q.push_back(g);
        is.wr   = p_wr[g];
        is.addr = p_addr[g];
        is.data = p_data[g];
        exp_issue_q.push_back(is);
        wr      = p_wr[g];
        ref_ptr = (g + 1) % NUM_CH;
        seen = 1'b0;
        got  = '0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            got  = reqReady;
            seen = (got != '0);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout: no reqReady within 20 cycles, expected channel %0d", g);
            finish_tb();
        end
        @(posedge clk); #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (got[c]) begin
                pend[c]     = 1'b0;
                reqValid[c] = 1'b0;
            end
        end
        repeat (r) begin @(posedge clk); #1; end
        mcReqReady = 1'b1;
        @(posedge clk); #1;
        mcReqReady = 1'b0;
        c_h = cyc;
    endtask

    // k = WAIT cycle of the completion; k > TIMEOUT means the watchdog fires first
    // and the completion arrives late (dropped). A wrong-type completion is injected earlier.
    task automatic run_txn(input int k, input int r, input logic [LINE_W-1:0] line);
        int    g;
        int    c_h;
        int    j;
        logic  wr;
        resp_t rs;
        if (pick() < 0) return;
        issue_phase(r, g, wr, c_h);
        j = (k > 1) ? int'($urandom_range(1, ((k > TIMEOUT) ? TIMEOUT : k) - 1)) : 0;
        rs.ch = g;
        if (k <= TIMEOUT) begin
            if (!wr) last_data = line;
            rs.err = 1'b0;
            rs.cyc = c_h + k;
        end else begin
            rs.err = 1'b1;
            rs.cyc = c_h + TIMEOUT;
        end
        rs.data = last_data;
        exp_resp_q.push_back(rs);
        for (int w = 1; w <= k; w++) begin
            mcRespData = rand_line();
            if (w == k) begin
                if (wr) mcWrDone = 1'b1;
                else begin
                    mcRespValid = 1'b1;
                    mcRespData  = line;
                end
            end else if (w == j) begin
                if (wr) mcRespValid = 1'b1;
                else    mcWrDone    = 1'b1;
            end
            @(posedge clk); #1;
            mcRespValid = 1'b0;
            mcWrDone    = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_reqReady"},   reqReady,   '0);
        check({tag, "_respValid"},  respValid,  '0);
        check({tag, "_respErr"},    respErr,    '0);
        check({tag, "_respData"},   respData,   '0);
        check({tag, "_mcReqValid"}, mcReqValid, '0);
        check({tag, "_mcReqWrite"}, mcReqWrite, '0);
        check({tag, "_mcReqAddr"},  mcReqAddr,  '0);
        check({tag, "_mcReqData"},  mcReqData,  '0);
        check({tag, "_timeoutEx"},  timeoutEx,  '0);
        check({tag, "_busy"},       busy,       '0);
    endtask

    // Monitors: grant, controller handshake and response streams are checked independently.
    int     grant_cyc = -10;
    int     mg;
    issue_t mi;
    resp_t  mr;
    always @(negedge clk) begin
        if (!rst) begin
            if (reqReady != '0) begin
                if (exp_grant_q.size() == 0) check("unexpected_grant", reqReady, '0);
                else begin
                    mg = exp_grant_q.pop_front();
                    check("grant", reqReady, 1 << mg);
                    check("busy_in_idle", busy, '0);
                    grant_cyc = cyc;
                end
            end
            if (cyc == grant_cyc + 1) check("issue_next_cycle", mcReqValid, 1);
            if (mcReqValid && mcReqReady) begin
                if (exp_issue_q.size() == 0) check("unexpected_issue", mcReqValid, '0);
                else begin
                    mi = exp_issue_q.pop_front();
                    check("mc_write", mcReqWrite, mi.wr);
                    check("mc_addr",  mcReqAddr,  mi.addr);
                    check("mc_data",  mcReqData,  mi.data);
                    check("busy_in_issue", busy, 1);
                end
            end
            if (respValid != '0) begin
                if (exp_resp_q.size() == 0) check("unexpected_resp", respValid, '0);
                else begin
                    mr = exp_resp_q.pop_front();
                    check("resp_owner", respValid, 1 << mr.ch);
                    check("resp_err",   respErr,   mr.err);
                    check("resp_data",  respData,  mr.data);
                    check("timeout_ex", timeoutEx, mr.err);
                    check("resp_cycle", cyc,       mr.cyc);
                end
            end else begin
                if (timeoutEx) check("stray_timeout_ex", timeoutEx, '0);
                if (exp_resp_q.size() != 0 && cyc > exp_resp_q[0].cyc) begin
                    check("missing_resp", respValid, 1 << exp_resp_q[0].ch);
                    void'(exp_resp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        checks++;
        failures++;
        $display("FAIL global_timeout: simulation still running at cycle %0d, limit 50000", cyc);
        finish_tb();
    end

    initial begin
        int g;
        int c_h;
        int k;
        logic wr;
        rst         = 1'b1;
        reqValid    = '0;
        reqWrite    = '0;
        reqAddr     = '0;
        reqData     = '0;
        mcReqReady  = 1'b0;
        mcRespValid = 1'b0;
        mcRespData  = '0;
        mcWrDone    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) pend[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // Single read with an immediate handshake and first-cycle completion.
        add_req(0, 1'b0, 32'h100, rand_line());
        run_txn(1, 0, {64{8'hA5}});

        // Evict on channel 1 finishing after 5 WAIT cycles; respData must keep the read line.
        add_req(1, 1'b1, 32'h2000, {16{32'hDEADBEEF}});
        run_txn(5, 1, rand_line());

        // Watchdog expiry followed by a late read response that must be dropped.
        add_req(0, 1'b0, 32'h300, rand_line());
        run_txn(TIMEOUT + 3, 0, rand_line());

        // Completion on the very cycle the watchdog would expire.
        add_req(1, 1'b0, 32'h400, rand_line());
        run_txn(TIMEOUT, 2, rand_line());

        // Both channels requesting continuously.
        for (int t = 0; t < 8; t++) begin
            for (int c = 0; c < NUM_CH; c++) if (!pend[c]) add_random(c);
            run_txn(int'($urandom_range(1, TIMEOUT)), int'($urandom_range(0, 2)), rand_line());
        end

        for (int t = 0; t < 200; t++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!pend[c] && $urandom_range(0, 2) == 0) add_random(c);
            end
            if (num_pend() == 0) add_random(int'($urandom_range(0, NUM_CH - 1)));
            if (num_pend() == 1 && $urandom_range(0, 5) == 0) k = int'($urandom_range(TIMEOUT + 1, TIMEOUT + 3));
            else k = int'($urandom_range(1, TIMEOUT));
            run_txn(k, int'($urandom_range(0, 2)), rand_line());
        end
        while (num_pend() != 0) run_txn(2, 0, rand_line());

        // Reset while a transaction is in WAIT; a response afterwards must be dropped.
        add_req(1, 1'b0, 32'h500, rand_line());
        issue_phase(0, g, wr, c_h);
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        ref_ptr   = 0;
        last_data = '0;
        check_reset_outputs("reset_in_wait");
        mcRespValid = 1'b1;
        mcRespData  = rand_line();
        @(posedge clk); #1;
        mcRespValid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        for (int c = 0; c < NUM_CH; c++) add_random(c);
        run_txn(3, 0, rand_line());
        run_txn(2, 1, rand_line());

        repeat (12) begin @(posedge clk); #1; end
        check("grant_queue_drained", exp_grant_q.size(), '0);
        check("issue_queue_drained", exp_issue_q.size(), '0);
        check("resp_queue_drained",  exp_resp_q.size(),  '0);
        finish_tb();
    end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Parametrised arbiter between the CPU's cache-miss/evict requesters and the single memory-controller port. It generalises the current fixed pair of instruction and data DMA channels to NUM_CH requesters. It adds round-robin fairness, read and write (evict) transactions on one port, and a response watchdog that raises a memory-access exception when the memory controller stops answering. It sits between the fetch/memory stages and the memory controller.

## Interface
- NUM_CH, 2, number of requesters; channel 0 is fetch, channel 1 is data cache.
- ADDR_W, 32, request address width.
- LINE_W, 512, cache line width.
- TIMEOUT, 1024, maximum WAIT cycles before the request is aborted; 0 disables the watchdog.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- reqValid  in  NUM_CH  per-channel request pending; held until reqReady.
- reqWrite  in  NUM_CH  1 = line write (evict), 0 = line read.
- reqAddr  in  NUM_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- reqData  in  NUM_CH*LINE_W  per-channel write line.
- reqReady  out  NUM_CH  one-hot, one-cycle acceptance pulse.
- respValid  out  NUM_CH  one-hot, one-cycle completion pulse to the owner.
- respErr  out  1  qualifies respValid: transaction aborted by the watchdog.
- respData  out  LINE_W  read line, broadcast; valid with respValid on a read.
- mcReqValid  out  1  request to the memory controller.
- mcReqWrite  out  1  request type.
- mcReqAddr  out  ADDR_W  request address.
- mcReqData  out  LINE_W  write line.
- mcReqReady  in  1  memory controller accepts the request.
- mcRespValid  in  1  read line returned on mcRespData.
- mcRespData  in  LINE_W  read line.
- mcWrDone  in  1  write committed to host memory.
- timeoutEx  out  1  one-cycle exception pulse to the cause register.
- busy  out  1  state is not IDLE.

## Operation
- Only one transaction is outstanding at a time. The FSM states are IDLE, ISSUE and WAIT.
- IDLE:
  - Pick the first channel with reqValid set, searching upward from ptr and wrapping modulo NUM_CH.
  - Assert reqReady for that channel.
  - Latch its write flag, address and data into the mc* registers and into owner.
  - Set ptr to owner+1, wrapping NUM_CH-1 to 0.
  - Go to ISSUE.
  - With no valid request, stay in IDLE and leave ptr unchanged.
- ISSUE:
  - mcReqValid is high and the mc* outputs are held stable.
  - When mcReqReady is high, go to WAIT and clear the timer.
- WAIT:
  - For a read, mcRespValid completes the transaction: respData is loaded from mcRespData.
  - For a write, mcWrDone completes the transaction; respData is unchanged.
  - On completion, pulse respValid[owner] with respErr=0 and go to IDLE.
  - The timer increments every WAIT cycle. If it reaches TIMEOUT (and TIMEOUT≠0):
    - pulse respValid[owner] with respErr=1;
    - pulse timeoutEx;
    - go to IDLE.
- The wrong-type completion signal is ignored in WAIT: mcWrDone during a read, mcRespValid during a write.
- mcRespValid and mcWrDone received in IDLE or ISSUE are dropped; this covers late responses after a timeout.
- If completion and timeout expiry occur in the same cycle, the completion wins: respErr=0 and no timeoutEx.
- Timer width is $clog2(TIMEOUT+1) and the timer saturates (never wraps).

## Timing
- Reset values:
  - state is IDLE, ptr is 0, timer is 0;
  - every output is 0, including respData.
- reqReady is combinational in IDLE. The request is accepted on the edge at the end of cycle T.
- mcReqValid is first high in cycle T+1.
- mcRespValid is sampled only in WAIT. Earliest completion sample is at T+2, so the earliest respValid is in T+3, one cycle after the sample.
- respValid, respErr, respData and timeoutEx are registered; each pulse lasts exactly one cycle.
- The earliest next acceptance is in the same cycle as respValid, because the state is already IDLE.
- Reset asserted mid-transaction:
  - everything returns to reset values on the next edge;
  - the in-flight transaction is abandoned with no respValid;
  - a memory-controller response after reset is dropped, since the state is IDLE.
- NUM_CH=1 is legal: ptr stays at 0.

## Structure
- Shared package mem_arb_pkg:
  - arb_state_t enum (IDLE, ISSUE, WAIT);
  - default localparams for LINE_W and ADDR_W.
- Sub-module rr_arbiter, parametrised by NUM_CH:
  - purely combinational;
  - inputs are the request vector and ptr;
  - outputs are the one-hot grant and its index.
- The top level holds the FSM, the ptr, the owner and the transaction registers, and the watchdog counter.

## Test plan
- Single read: reqValid=01, addr 0x100. Expect reqReady[0] in T, mcReqValid from T+1, mcReqReady in T+1, mcRespValid with line 0xA5… in T+2, then respValid=01, respErr=0, respData=0xA5… in T+3.
- Fairness: NUM_CH=2, both channels request continuously. Grants alternate 0,1,0,1. After reset the first grant goes to channel 0.
- Evict: reqWrite[1]=1 with line 0xDEAD…, mcWrDone after 5 WAIT cycles. Expect mcReqData=0xDEAD… and respValid=10, with respData unchanged.
- Watchdog: TIMEOUT=8 and no response. Expect respValid with respErr=1 and timeoutEx after 8 WAIT cycles. A mcRespValid 3 cycles later is dropped and produces no respValid.
- Race: completion and timeout expiry in the same cycle. Expect respErr=0 and no timeoutEx.
- Reset during WAIT: rst for 1 cycle. Expect all outputs 0 and busy=0. A subsequent mcRespValid is ignored, and the next request is granted normally starting from channel 0.
